// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between NREQ writeback
//   requesters. One requester is granted per cycle in round-robin order and
//   its address/data are registered onto the write port one cycle later.
//   Writes to x0 are consumed but never enabled; flush blocks the current
//   grant.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, dominates flush and requests
//   flush      blocks grants this cycle (wr_en is 0 on the next cycle)
//   req_valid  per-requester write request
//   req_addr   requester i destination register at [i*AW +: AW]
//   req_data   requester i write data at [i*XLEN +: XLEN]
//   req_ready  one-hot (or zero) grant, combinational from req_valid
//   wr_en      registered register-file write enable
//   wr_addr    registered register-file write address
//   wr_data    registered register-file write data
//   grant_id   registered index of the requester behind the current wr_*
module rf_write_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*XLEN-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [XLEN-1:0]        wr_data,
    output logic [1:0]             grant_id
);

    localparam int unsigned PW = 2;

    logic [PW-1:0]   ptr_q,      ptr_d;
    logic            wr_en_q,    wr_en_d;
    logic [AW-1:0]   wr_addr_q,  wr_addr_d;
    logic [XLEN-1:0] wr_data_q,  wr_data_d;
    logic [PW-1:0]   grant_id_q, grant_id_d;

    logic            found;
    logic [PW-1:0]   win_idx;
    logic            grant_vld;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    // Round-robin search: first pass covers ptr..NREQ-1, the second pass only
    // matters when nothing matched there, so its lowest hit is the wrap-around
    // winner below ptr.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && (i >= 32'(ptr_q)) && req_valid[i]) begin
                found   = 1'b1;
                win_idx = PW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found   = 1'b1;
                win_idx = PW'(i);
            end
        end
    end

    // Reset and flush both veto the grant.
    always_comb begin
        grant_vld = found && !rst && !flush;
        req_ready = '0;
        if (grant_vld) begin
            req_ready = NREQ'(1) << win_idx;
        end
    end

    // Winner payload mux.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Next state: pointer moves past the winner; write port holds its payload
    // when idle, and x0 targets are consumed without enabling the write.
    always_comb begin
        ptr_d      = ptr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        if (grant_vld) begin
            ptr_d      = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
            wr_en_d    = (sel_addr != '0);
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
            grant_id_d = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between up to four writeback requesters (e.g. ALU, load unit, CSR unit).
- Grants one requester per cycle in round-robin order and registers the winning address/data onto the write port with one-cycle latency.
- Suppresses writes to x0 and supports a pipeline flush.
- Sits between the execute/memory writeback sources and the 32-bit register array.

Parameters:
- NREQ, 3, number of requesters; legal range 2..4.
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous flush; blocks grants this cycle and cancels the write issued next cycle.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*AW  destination register; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*XLEN  write data; requester i uses bits [i*XLEN +: XLEN].
- req_ready  output  NREQ  grant, one-hot or zero; a transfer occurs when req_valid[i] & req_ready[i].
- wr_en  output  1  register-file write enable, registered.
- wr_addr  output  AW  register-file write address, registered.
- wr_data  output  XLEN  register-file write data, registered.
- grant_id  output  2  index of the requester that produced the current wr_* values, registered.

Behaviour:
- State:
  - ptr: round-robin priority pointer, 0..NREQ-1.
  - Output registers: wr_en, wr_addr, wr_data, grant_id.
- Reset: while rst=1 at a clock edge:
  - ptr<=0, wr_en<=0, wr_addr<=0, wr_data<=0, grant_id<=0.
  - req_ready is forced to 0 combinationally.
  - rst has priority over flush and over all requests.
- Arbitration (combinational):
  - Search indices ptr, ptr+1, ..., wrapping modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other req_ready bits are 0.
  - If no request, or if rst=1 or flush=1, req_ready = 0.
- Handshake:
  - Requesters hold req_valid, addr and data stable until they see ready.
  - Ready may depend combinationally on valid, but valid must never depend on ready.
  - A non-granted requester keeps waiting; its request is not lost.
- Pointer update:
  - On a grant to i: ptr <= (i+1) mod NREQ, wrapping from NREQ-1 to 0.
  - No grant (idle, flush or rst): ptr unchanged (0 under rst).
- Write issue, latency 1 cycle: on the edge where requester i is granted:
  - wr_addr<=req_addr[i], wr_data<=req_data[i], grant_id<=i.
  - wr_en<=1 only if req_addr[i]!=0.
- x0 writes: the requester is still granted and consumed, ptr still advances, and wr_addr/wr_data/grant_id are updated, but wr_en=0.
- No grant on an edge: wr_en<=0; wr_addr, wr_data and grant_id hold their previous values.
- Flush:
  - flush=1 in a cycle: no grant that cycle and wr_en<=0 at that edge.
  - A write already presented on wr_* during the flush cycle is not recalled; it completes.
- Max throughput: one write per cycle. A requester holding valid continuously waits at most NREQ-1 cycles (starvation-free).
- Reset mid-operation:
  - Pending requests are not acknowledged.
  - wr_en is 0 from the first post-reset cycle.
  - Arbitration restarts from requester 0.
- Unused requester indices (NREQ<4) never appear on grant_id.

Test Plan:
- Reset: assert rst 2 cycles with all req_valid=1 -> req_ready=000 throughout; wr_en=0, wr_addr=0, wr_data=0, grant_id=0 after the first edge; first grant after release goes to requester 0.
- Single requester: req1 valid, addr=5, data=0xDEADBEEF -> req_ready=010 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=1; following cycle wr_en=0 once valid drops.
- Round-robin with wrap: all three valid continuously (addrs 1/2/3) from reset -> grants 0,1,2,0,1 on consecutive cycles; wr_addr sequence 1,2,3,1,2 one cycle later; wr_en=1 every cycle.
- x0 suppression: req2 valid with addr=0, data=0x1234 -> req_ready[2]=1; next cycle wr_en=0, grant_id=2; ptr advances, so the next simultaneous req0/req2 grant goes to req0.
- Flush: req0 valid during a flush=1 cycle -> req_ready=000 and wr_en=0 next cycle; req0 is granted the cycle after flush drops.
- Reset mid-stream: all valid with ptr=2, then assert rst one cycle -> no grant that cycle, wr_en=0 next cycle, ptr back to 0; first grant after release goes to req0.
